// File: rtl/mem_stage_access_unit.sv
// ---------------------------------------------------------------------------
// mem_stage_access_unit
//
// Purpose:
//   Consumer side of the EX/MEM pipeline register. It samples the EX/MEM
//   fields and either forwards the ALU result directly (one cycle) or runs a
//   data-memory load/store over a req/ack handshake. While an access is
//   outstanding it stalls the front of the pipeline. The result toward the
//   MEM/WB register is registered and qualified by a one-cycle valid strobe.
//
// Handshake:
//   mem_req rises when the unit enters ACCESS. It stays high, with mem_we,
//   mem_addr and mem_wdata held stable, until mem_ack is seen high at a
//   rising edge. mem_ack is a single-cycle strobe, and mem_rdata is sampled
//   on that same edge. mem_ack is ignored while no request is outstanding.
//
// Configuration macro:
//   MEM_TIMEOUT_EN - when defined, an access that waits TIMEOUT cycles
//                    without an ack is aborted. The abort produces a
//                    result-less valid strobe and sets the sticky err_out.
//                    When undefined, the unit waits indefinitely and err_out
//                    is tied to 0.
//
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   wbs_in .. ni_in      EX/MEM fields: writeback en, store en, load select,
//                        ALU result / address, store data, wm flag, bubble flag
//   mem_req/we/addr/wdata  memory request channel (outputs)
//   mem_rdata, mem_ack   memory response channel (inputs)
//   stall_out            holds EX/MEM and earlier stages during an access
//   valid_out            one-cycle strobe: result fields updated
//   wbs_out, wm_out, ni_out, result_out  fields toward MEM/WB (held)
//   err_out              sticky access-timeout flag
// ---------------------------------------------------------------------------
module mem_stage_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              mm_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] memData_in,
    input  logic              wm_in,
    input  logic              ni_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              valid_out,
    output logic              wbs_out,
    output logic              wm_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] result_out,
    output logic              err_out
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Instruction latched for the duration of an access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              wbs_lat_q, wbs_lat_d;
    logic              wm_lat_q, wm_lat_d;
    logic              load_q, load_d;

    // Registered result toward MEM/WB
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wbs_out_q, wbs_out_d;
    logic              wm_out_q, wm_out_d;
    logic              ni_out_q, ni_out_d;

    logic              is_mem_op;
    logic              timeout_hit;

    assign is_mem_op = !ni_in && (wme_in || mm_in);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q counts completed ack-less ACCESS cycles; the access is dropped
    // at the end of the TIMEOUT-th such cycle.
    assign timeout_hit = (state_q == ACCESS) && !mem_ack
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_out     = 1'b0;
`endif

    // ---------------- state register (and datapath registers) -------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            alu_q     <= '0;
            wbs_lat_q <= 1'b0;
            wm_lat_q  <= 1'b0;
            load_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            wbs_out_q <= 1'b0;
            wm_out_q  <= 1'b0;
            ni_out_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            alu_q     <= alu_d;
            wbs_lat_q <= wbs_lat_d;
            wm_lat_q  <= wm_lat_d;
            load_q    <= load_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            wbs_out_q <= wbs_out_d;
            wm_out_q  <= wm_out_d;
            ni_out_q  <= ni_out_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_mem_op) state_d = ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        alu_d     = alu_q;
        wbs_lat_d = wbs_lat_q;
        wm_lat_d  = wm_lat_q;
        load_d    = load_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        wbs_out_d = wbs_out_q;
        wm_out_d  = wm_out_q;
        ni_out_d  = ni_out_q;

        case (state_q)
            IDLE: begin
                if (ni_in) begin
                    ni_out_d  = 1'b1;
                    wbs_out_d = 1'b0;
                end else if (is_mem_op) begin
                    we_d      = wme_in;
                    addr_d    = ALUresult_in[ADDR_W-1:0];
                    wdata_d   = memData_in;
                    alu_d     = ALUresult_in;
                    wbs_lat_d = wbs_in;
                    wm_lat_d  = wm_in;
                    // A store wins when both wme and mm are set
                    load_d    = mm_in && !wme_in;
                end else begin
                    valid_d   = 1'b1;
                    result_d  = ALUresult_in;
                    wbs_out_d = wbs_in;
                    wm_out_d  = wm_in;
                    ni_out_d  = 1'b0;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    valid_d   = 1'b1;
                    result_d  = load_q ? mem_rdata : alu_q;
                    wbs_out_d = wbs_lat_q;
                    wm_out_d  = wm_lat_q;
                    ni_out_d  = 1'b0;
                end else if (timeout_hit) begin
                    // Aborted access: strobe with no writeback
                    valid_d   = 1'b1;
                    result_d  = '0;
                    wbs_out_d = 1'b0;
                    wm_out_d  = wm_lat_q;
                    ni_out_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_req    = (state_q == ACCESS);
    assign stall_out  = (state_q == ACCESS);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign valid_out  = valid_q;
    assign result_out = result_q;
    assign wbs_out    = wbs_out_q;
    assign wm_out     = wm_out_q;
    assign ni_out     = ni_out_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// ---------------------------------------------------------------------------
// Directed testbench for mem_stage_access_unit (DATA_W=16, ADDR_W=16,
// TIMEOUT=15). Inputs change 1 time unit after a rising edge, and outputs
// are checked at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_in, wme_in, mm_in, wm_in, ni_in;
    logic [15:0] ALUresult_in, memData_in;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        stall_out, valid_out, wbs_out, wm_out, ni_out, err_out;
    logic [15:0] result_out;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in),
        .ALUresult_in(ALUresult_in), .memData_in(memData_in),
        .wm_in(wm_in), .ni_in(ni_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .valid_out(valid_out), .wbs_out(wbs_out),
        .wm_out(wm_out), .ni_out(ni_out), .result_out(result_out),
        .err_out(err_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ni, input logic wme, input logic mm,
                         input logic wbs, input logic wm,
                         input logic [15:0] alu, input logic [15:0] md);
        ni_in = ni; wme_in = wme; mm_in = mm; wbs_in = wbs; wm_in = wm;
        ALUresult_in = alu; memData_in = md;
    endtask

    task automatic bubble();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        bubble();
        tick(); tick();
        tests_run++;
        if ({mem_req, stall_out, valid_out, wbs_out, wm_out, ni_out, err_out, mem_we} !== 8'b0000_0100) begin
            tests_failed++;
            $display("FAIL reset_flags: got req=%b stall=%b valid=%b wbs=%b wm=%b ni=%b err=%b we=%b expected all 0 except ni=1",
                     mem_req, stall_out, valid_out, wbs_out, wm_out, ni_out, err_out, mem_we);
        end
        tests_run++;
        if ({mem_addr, mem_wdata, result_out} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h wdata=%h result=%h expected 0",
                     mem_addr, mem_wdata, result_out);
        end
        // Reset in the middle of an outstanding load
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick();
        bubble();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL reset_mid_req: got req=%b addr=%h expected req=1 addr=0010", mem_req, mem_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0 || ni_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_access: got req=%b stall=%b valid=%b ni=%b expected 0 0 0 1",
                     mem_req, stall_out, valid_out, ni_out);
        end
    endtask

    task automatic test_alu_passthrough();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
        tick();
        bubble();
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h1234 || wbs_out !== 1'b1 ||
            wm_out !== 1'b1 || ni_out !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_pass: got valid=%b result=%h wbs=%b wm=%b ni=%b req=%b expected 1 1234 1 1 0 0",
                     valid_out, result_out, wbs_out, wm_out, ni_out, mem_req);
        end
        tick();
        tests_run++;
        if (valid_out !== 1'b0 || result_out !== 16'h1234 || ni_out !== 1'b1 ||
            wbs_out !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_strobe_hold: got valid=%b result=%h ni=%b wbs=%b req=%b expected 0 1234 1 0 0",
                     valid_out, result_out, ni_out, wbs_out, mem_req);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00A0, 16'h0000);
        tick();
        // Upstream is stalled; change the inputs to prove they are not resampled
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h6666);
        for (int i = 1; i <= 3; i++) begin
            tests_run++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h00A0 ||
                stall_out !== 1'b1 || valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_req_c%0d: got req=%b we=%b addr=%h stall=%b valid=%b expected 1 0 00a0 1 0",
                         i, mem_req, mem_we, mem_addr, stall_out, valid_out);
            end
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 16'hABCD;
            end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        bubble();
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'hABCD || wbs_out !== 1'b1 ||
            wm_out !== 1'b0 || mem_req !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_result: got valid=%b result=%h wbs=%b wm=%b req=%b stall=%b expected 1 abcd 1 0 0 0",
                     valid_out, result_out, wbs_out, wm_out, mem_req, stall_out);
        end
        tick();
        tests_run++;
        if (valid_out !== 1'b0 || result_out !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL load_hold: got valid=%b result=%h expected 0 abcd", valid_out, result_out);
        end
    endtask

    task automatic test_store();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4A81, 16'h7755);
        tick();
        bubble();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h4A81 ||
            mem_wdata !== 16'h7755 || stall_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 4a81 7755 1",
                     mem_req, mem_we, mem_addr, mem_wdata, stall_out);
        end
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h4A81 || wbs_out !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_result: got valid=%b result=%h wbs=%b req=%b expected 1 4a81 0 0",
                     valid_out, result_out, wbs_out, mem_req);
        end
    endtask

    task automatic test_bubble_conflict();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0033, 16'h0000);
        tick();
        tests_run++;
        if (mem_req !== 1'b0 || valid_out !== 1'b0 || stall_out !== 1'b0 || ni_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL bubble: got req=%b valid=%b stall=%b ni=%b expected 0 0 0 1",
                     mem_req, valid_out, stall_out, ni_out);
        end
        // mem_ack while IDLE must be ignored
        mem_ack = 1'b1; mem_rdata = 16'h0BAD;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0 || valid_out !== 1'b0 || result_out !== 16'h4A81) begin
            tests_failed++;
            $display("FAIL idle_ack: got req=%b valid=%b result=%h expected 0 0 4a81",
                     mem_req, valid_out, result_out);
        end
        // wme and mm both set: treated as a store
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0042, 16'h9999);
        tick();
        bubble();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h9999) begin
            tests_failed++;
            $display("FAIL conflict_req: got req=%b we=%b wdata=%h expected 1 1 9999",
                     mem_req, mem_we, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h0042 || wbs_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_result: got valid=%b result=%h wbs=%b expected 1 0042 1",
                     valid_out, result_out, wbs_out);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0000);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h1111 || wm_out !== 1'b1 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_load: got valid=%b result=%h wm=%b stall=%b expected 1 1111 1 0",
                     valid_out, result_out, wm_out, stall_out);
        end
        // The strobe cycle samples the next instruction
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h2222);
        tick();
        bubble();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 ||
            mem_wdata !== 16'h2222 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_store_req: got req=%b we=%b addr=%h wdata=%h valid=%b expected 1 1 0200 2222 0",
                     mem_req, mem_we, mem_addr, mem_wdata, valid_out);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h0200 || wbs_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_store_result: got valid=%b result=%h wbs=%b expected 1 0200 0",
                     valid_out, result_out, wbs_out);
        end
    endtask

    task automatic test_no_ack_wait();
        int n;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0077, 16'h0000);
        tick();
        bubble();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        tests_run++;
        if (n !== 15) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d req cycles expected 15", n);
        end
        tests_run++;
        if (valid_out !== 1'b1 || wbs_out !== 1'b0 || result_out !== 16'h0000 ||
            err_out !== 1'b1 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: got valid=%b wbs=%b result=%h err=%b stall=%b expected 1 0 0000 1 0",
                     valid_out, wbs_out, result_out, err_out, stall_out);
        end
        tick(); tick();
        tests_run++;
        if (err_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got err=%b valid=%b expected 1 0", err_out, valid_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err_clear: got err=%b expected 0", err_out);
        end
`else
        tests_run++;
        if (n !== 40 || stall_out !== 1'b1 || err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_timeout_wait: got %0d req cycles stall=%b err=%b expected 40 1 0",
                     n, stall_out, err_out);
        end
        mem_ack = 1'b1; mem_rdata = 16'h3C3C;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || result_out !== 16'h3C3C || mem_req !== 1'b0 || err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ack: got valid=%b result=%h req=%b err=%b expected 1 3c3c 0 0",
                     valid_out, result_out, mem_req, err_out);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu_passthrough();
        test_load();
        test_store();
        test_bubble_conflict();
        test_back_to_back();
        test_no_ack_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
Consumer side of the Execute/Memory pipeline register. It samples the EX/MEM outputs (wbs, wme, mm, ALUresult, memData, wm, ni) and carries out the data-memory load or store over a req/ack handshake. It stalls the front of the pipeline while the access is outstanding and presents a registered result toward the Memory/Writeback register.

Parameters:
DATA_W, 16, width of ALUresult, memData and memory data bus
ADDR_W, 16, memory address width; mem_addr = ALUresult_in[ADDR_W-1:0]
TIMEOUT, 15, max cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
wbs_in  in  1  register writeback enable from EX/MEM
wme_in  in  1  memory write (store) enable from EX/MEM
mm_in  in  1  memory-to-register select (load) from EX/MEM
ALUresult_in  in  DATA_W  address / ALU result from EX/MEM
memData_in  in  DATA_W  store data from EX/MEM
wm_in  in  1  writeback mode flag, passed through
ni_in  in  1  no-instruction (bubble) flag
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  memory address; valid while mem_req
mem_wdata  out  DATA_W  store data; valid while mem_req
mem_rdata  in  DATA_W  read data; valid when mem_ack=1
mem_ack  in  1  single-cycle access-complete strobe
stall_out  out  1  hold EX/MEM and earlier stages
valid_out  out  1  one-cycle strobe: result fields valid
wbs_out  out  1  writeback enable toward MEM/WB
wm_out  out  1  wm passthrough
ni_out  out  1  ni passthrough
result_out  out  DATA_W  load data or ALU result
err_out  out  1  sticky access-timeout flag

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE. mem_req, mem_we, stall_out, valid_out, wbs_out, wm_out, err_out = 0. ni_out = 1. mem_addr, mem_wdata, result_out = 0. Reset overrides any outstanding access; mem_req is low after the edge.
- FSM states: IDLE, ACCESS.
- IDLE, ni_in=1: next cycle valid_out=0, ni_out=1, wbs_out=0. No memory access.
- IDLE, ni_in=0, wme_in=0, mm_in=0: latency 1. Next cycle valid_out=1, result_out=ALUresult_in, wbs_out=wbs_in, wm_out=wm_in, ni_out=0.
- IDLE, ni_in=0, wme_in=1 or mm_in=1: latch all inputs and go to ACCESS. Next cycle mem_req=1, stall_out=1, valid_out=0. mem_we=wme_in. If wme_in and mm_in are both 1, the access is a store and no load is performed.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata are held stable. stall_out=1.
- ACCESS with mem_ack=1 at an edge: next cycle state=IDLE, mem_req=0, stall_out=0, valid_out=1.
  - Load: result_out=mem_rdata sampled at that edge.
  - Store: result_out=latched ALUresult, wbs_out=latched wbs.
- Minimum load/store latency (same-cycle ack after req): 2 cycles from input sample to valid_out.
- valid_out is a single-cycle strobe. result_out, wbs_out, wm_out and ni_out hold their values until the next update.
- mem_ack while IDLE is ignored.
- Inputs are not sampled in ACCESS; upstream holds them because stall_out=1.
- Back-to-back memory ops: the IDLE cycle that carries valid_out also samples the next instruction.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a cycle counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When the counter reaches TIMEOUT:
  - The access aborts; next cycle state=IDLE, mem_req=0, stall_out=0.
  - valid_out=1 with result_out=0 and wbs_out=0, so no writeback occurs.
  - err_out=1, sticky until rst.
- Undefined: the unit waits in ACCESS indefinitely; err_out is tied to 0 and no counter is built.

Test Plan:
1. Reset mid-access: load to 0x0010, no ack, rst=1 on cycle 3 -> next cycle mem_req=0, stall_out=0, valid_out=0, ni_out=1.
2. ALU passthrough: ni=0, wme=0, mm=0, wbs=1, ALUresult=0x1234, wm=1 -> one cycle later valid_out=1, result_out=0x1234, wbs_out=1, wm_out=1, mem_req never asserted.
3. Load: mm=1, wbs=1, ALUresult=0x00A0, ack after 3 cycles with rdata=0xABCD -> mem_req=1, we=0, addr=0x00A0 for 3 cycles, stall_out=1 throughout. Cycle after ack: valid_out=1, result_out=0xABCD.
4. Store with ack in first ACCESS cycle: wme=1, ALUresult=0x4A81, memData=0x7755 -> mem_we=1, mem_wdata=0x7755 for 1 cycle, then valid_out=1, result_out=0x4A81.
5. Bubble and conflict: ni=1 with mm=1 -> no mem_req, valid_out=0. Then wme=mm=1 -> store performed (mem_we=1).
6. MEM_TIMEOUT_EN, TIMEOUT=15, load never acked -> mem_req drops after 15 ACCESS cycles, valid_out=1, wbs_out=0, err_out=1 and stays 1 until rst.
